// File: rtl/spm_arbiter.sv
// Single-port SPM arbiter between the IF fetch port and the MEM data port.
// Define ARB_FAIR_EN to enable the IF starvation counter (MAX_WAIT / CNT_W).
module spm_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] if_addr,
  input  logic        if_as_,
  output logic [31:0] if_rd_data,
  output logic        if_rdy,
  output logic        if_busy,
  input  logic [29:0] mem_addr,
  input  logic        mem_as_,
  input  logic        mem_rw,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        mem_rdy,
  output logic        mem_busy,
  output logic [29:0] spm_addr,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [31:0] spm_wr_data,
  input  logic [31:0] spm_rd_data
);

  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_MEM_RD, TAG_MEM_WR} tag_e;

  typedef struct packed {
    logic        as_n;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
  } spm_req_t;

  tag_e     tag, tag_nxt;
  spm_req_t req;
  logic     if_req, mem_req, if_pri, if_gnt, mem_gnt;

  // Requests are masked during reset so every output falls to its idle value.
  assign if_req  = ~if_as_  & ~reset;
  assign mem_req = ~mem_as_ & ~reset;
  assign if_gnt  = if_req & (~mem_req | if_pri);
  assign mem_gnt = mem_req & ~if_gnt;

  assign if_busy  = if_req  & ~if_gnt;
  assign mem_busy = mem_req & ~mem_gnt;

`ifdef ARB_FAIR_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  assign if_pri = (wait_cnt == MAX_CNT);

  // Counts consecutive IF losses; any edge where IF is not stalled clears it.
  always_comb begin
    wait_cnt_nxt = '0;
    if (if_busy) wait_cnt_nxt = (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt <= '0;
    else       wait_cnt <= wait_cnt_nxt;
  end
`else
  assign if_pri = 1'b0;
`endif

  always_comb begin
    req     = '{as_n: 1'b1, rw: 1'b1, addr: '0, wr_data: '0};
    tag_nxt = TAG_NONE;
    if (mem_gnt) begin
      req     = '{as_n: 1'b0, rw: mem_rw, addr: mem_addr, wr_data: mem_wr_data};
      tag_nxt = mem_rw ? TAG_MEM_RD : TAG_MEM_WR;
    end else if (if_gnt) begin
      req     = '{as_n: 1'b0, rw: 1'b1, addr: if_addr, wr_data: '0};
      tag_nxt = TAG_IF;
    end
  end

  assign spm_as_     = req.as_n;
  assign spm_rw      = req.rw;
  assign spm_addr    = req.addr;
  assign spm_wr_data = req.wr_data;

  always_ff @(posedge clk) begin
    if (reset) tag <= TAG_NONE;
    else       tag <= tag_nxt;
  end

  // Return steering; reset kills an in-flight return in the same cycle.
  assign if_rdy      = (tag == TAG_IF) & ~reset;
  assign if_rd_data  = if_rdy ? spm_rd_data : '0;
  assign mem_rdy     = ((tag == TAG_MEM_RD) | (tag == TAG_MEM_WR)) & ~reset;
  assign mem_rd_data = ((tag == TAG_MEM_RD) & ~reset) ? spm_rd_data : '0;

endmodule

// File: tb/tb_spm_arbiter.sv
// Directed + random bench for spm_arbiter with a registered SRAM model and a
// cycle-level reference of the arbitration rules.
module tb_spm_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] if_addr, mem_addr, spm_addr;
  logic        if_as_, mem_as_, mem_rw, spm_as_, spm_rw;
  logic [31:0] mem_wr_data, spm_wr_data, spm_rd_data;
  logic [31:0] if_rd_data, mem_rd_data;
  logic        if_rdy, if_busy, mem_rdy, mem_busy;

  always #5 clk = ~clk;

  spm_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .if_addr(if_addr), .if_as_(if_as_), .if_rd_data(if_rd_data), .if_rdy(if_rdy), .if_busy(if_busy),
    .mem_addr(mem_addr), .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy), .mem_busy(mem_busy),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data)
  );

  function automatic logic [31:0] init_val(int a);
    return (a == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
  endfunction

  // Registered SRAM: read data appears the cycle after the strobe.
  bit [31:0] sram [64];
  bit [63:0] wrote;
  always @(posedge clk) begin
    if (!spm_as_) begin
      if (spm_rw) spm_rd_data <= wrote[spm_addr[5:0]] ? sram[spm_addr[5:0]] : init_val(int'(spm_addr[5:0]));
      else begin
        sram[spm_addr[5:0]]  <= spm_wr_data;
        wrote[spm_addr[5:0]] <= 1'b1;
      end
    end
  end

  // Reference state: 0 none, 1 IF, 2 MEM read, 3 MEM write pending return.
  logic [31:0] ref_mem [64];
  int          exp_tag, starve, errors, checks;
  logic [31:0] exp_ret;

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", name, obs, exp);
    end
  endtask

  task automatic step(bit r, bit ia, logic [29:0] iaddr, bit ma, bit mrw, logic [29:0] maddr, logic [31:0] mwd);
    bit ir, mr, iw, mw, ret_if, ret_mem;
    reset = r; if_as_ = ia; if_addr = iaddr;
    mem_as_ = ma; mem_rw = mrw; mem_addr = maddr; mem_wr_data = mwd;
    #1;
    ir = !r && !ia;
    mr = !r && !ma;
`ifdef ARB_FAIR_EN
    iw = ir && (!mr || starve == MAX_WAIT);
`else
    iw = ir && !mr;
`endif
    mw = mr && !iw;
    ret_if  = !r && exp_tag == 1;
    ret_mem = !r && exp_tag >= 2;
    chk("spm_as_",     spm_as_,     (iw || mw) ? 0 : 1);
    chk("spm_addr",    spm_addr,    iw ? iaddr : (mw ? maddr : 30'd0));
    chk("spm_rw",      spm_rw,      mw ? mrw : 1);
    chk("spm_wr_data", spm_wr_data, mw ? mwd : 0);
    chk("if_busy",     if_busy,     ir && !iw);
    chk("mem_busy",    mem_busy,    mr && !mw);
    chk("if_rdy",      if_rdy,      ret_if);
    chk("if_rd_data",  if_rd_data,  ret_if ? exp_ret : 0);
    chk("mem_rdy",     mem_rdy,     ret_mem);
    chk("mem_rd_data", mem_rd_data, (ret_mem && exp_tag == 2) ? exp_ret : 0);
    if (r) begin
      exp_tag = 0;
      starve  = 0;
    end else begin
      if (iw) begin
        exp_tag = 1; exp_ret = ref_mem[iaddr[5:0]];
      end else if (mw && mrw) begin
        exp_tag = 2; exp_ret = ref_mem[maddr[5:0]];
      end else if (mw) begin
        exp_tag = 3; ref_mem[maddr[5:0]] = mwd;
      end else exp_tag = 0;
      starve = (ir && !iw) ? ((starve < MAX_WAIT) ? starve + 1 : MAX_WAIT) : 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    errors = 0; checks = 0; exp_tag = 0; starve = 0; exp_ret = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

    // reset state
    step(1, 1, 30'h3, 1, 0, 30'h5, 32'h55);
    step(1, 0, 30'h3, 0, 0, 30'h5, 32'h55);
    // IF-only fetch of 0x10
    step(0, 0, 30'h10, 1, 1, 30'h0, 32'h0);
    step(0, 1, 30'h0,  1, 1, 30'h0, 32'h0);
    // MEM write then read-back of 0x20
    step(0, 1, 30'h0, 0, 0, 30'h20, 32'h12345678);
    step(0, 1, 30'h0, 0, 1, 30'h20, 32'h0);
    step(0, 1, 30'h0, 1, 1, 30'h0,  32'h0);
    // conflict: MEM wins, IF granted next cycle
    step(0, 0, 30'h04, 0, 1, 30'h08, 32'h0);
    step(0, 0, 30'h04, 1, 1, 30'h0,  32'h0);
    step(0, 1, 30'h0,  1, 1, 30'h0,  32'h0);
    // reset right after a MEM grant swallows its return
    step(0, 1, 30'h0,  0, 1, 30'h20, 32'h0);
    step(1, 1, 30'h0,  1, 1, 30'h0,  32'h0);
    step(0, 0, 30'h10, 1, 1, 30'h0,  32'h0);
    step(0, 1, 30'h0,  1, 1, 30'h0,  32'h0);
    // continuous conflict (fairness pattern when enabled)
    for (int i = 0; i < 12; i++) step(0, 0, 30'h11, 0, 1, 30'h12, 32'h0);
    // IF withdraws while busy, then conflicts again
    step(0, 0, 30'h13, 0, 0, 30'h14, 32'hA0A0A0A0);
    step(0, 0, 30'h13, 0, 1, 30'h14, 32'h0);
    step(0, 1, 30'h13, 0, 1, 30'h15, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 30'h16, 0, 0, 30'(17 + i), 32'(i * 3 + 1));
    step(0, 1, 30'h0, 1, 1, 30'h0, 32'h0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), 30'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30'($urandom_range(0, 63)), $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
